// File: rtl/bus_timer.sv
// Memory-mapped interval timer: CTRL/AR/CNTR/STAT registers behind a RAM-like
// bus port with one-cycle registered read data and a sticky period-end flag.
module bus_timer #(
  parameter int              DW     = 32,
  parameter logic [DW-1:0]   RST_AR = '0
) (
  input  logic          CLK,
  input  logic          RESETN,
  input  logic [31:0]   A,
  input  logic          CS,
  input  logic          WR,
  input  logic [DW-1:0] I,
  output logic [DW-1:0] O,
  output logic          CSO,
  output logic          IRQ
);

  logic [2:0]    ctrl, ctrl_nxt;
  logic [DW-1:0] ar, ar_nxt;
  logic [DW-1:0] cntr, cntr_nxt;
  logic          ov, ov_nxt;
  logic [DW-1:0] rdata;
  logic [1:0]    addr;
  logic          wr_en, rd_en, wrap;
  logic          unused_a;

  function automatic logic [DW-1:0] rd_mux(input logic [1:0] sel, input logic [2:0] c,
                                           input logic [DW-1:0] r_ar, input logic [DW-1:0] r_cntr,
                                           input logic r_ov);
    logic [DW-1:0] r;
    r = '0;
    case (sel)
      2'd0:    r[2:0] = c;
      2'd1:    r      = r_ar;
      2'd2:    r      = r_cntr;
      default: r[1:0] = {r_ov, c[0]};
    endcase
    return r;
  endfunction

  assign addr     = A[1:0];
  assign unused_a = ^A[31:2];
  assign wr_en    = CS & WR;
  assign rd_en    = CS & ~WR;
  // Wrap is judged on the pre-edge count and limit, independent of any same-cycle write.
  assign wrap     = ctrl[0] & (cntr >= ar);
  assign rdata    = rd_mux(addr, ctrl, ar, cntr, ov);

  always_comb begin
    ctrl_nxt = ctrl;
    ar_nxt   = ar;
    cntr_nxt = cntr;
    ov_nxt   = ov;
    if (ctrl[0]) begin
      if (wrap) begin
        cntr_nxt = '0;
        if (!ctrl[1]) ctrl_nxt[0] = 1'b0;
      end else begin
        cntr_nxt = cntr + DW'(1);
      end
    end
    // Bus writes override the counting updates computed above.
    if (wr_en) begin
      case (addr)
        2'd0:    ctrl_nxt = I[2:0];
        2'd1:    ar_nxt   = I;
        2'd2:    cntr_nxt = I;
        default: if (I[1]) ov_nxt = 1'b0;
      endcase
    end
    if (wrap) ov_nxt = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ctrl <= '0;
      ar   <= RST_AR;
      cntr <= '0;
      ov   <= 1'b0;
      O    <= '0;
      CSO  <= 1'b0;
      IRQ  <= 1'b0;
    end else begin
      ctrl <= ctrl_nxt;
      ar   <= ar_nxt;
      cntr <= cntr_nxt;
      ov   <= ov_nxt;
      O    <= rd_en ? rdata : '0;
      CSO  <= CS;
      IRQ  <= ov & ctrl[2];
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios plus randomized bus
// traffic compared against a cycle-level behavioural model of the register map.
module tb_bus_timer;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic [31:0] A;
  logic        CS, WR;
  logic [31:0] I;
  logic [31:0] O;
  logic        CSO, IRQ;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [2:0]  m_ctrl;
  logic [31:0] m_ar, m_cntr, m_o;
  logic        m_ov, m_cso, m_irq;

  bus_timer #(.DW(32), .RST_AR(32'd7)) dut (
    .CLK(CLK), .RESETN(RESETN), .A(A), .CS(CS), .WR(WR), .I(I),
    .O(O), .CSO(CSO), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_ctrl = 3'd0; m_ar = 32'd7; m_cntr = 32'd0; m_ov = 1'b0;
    m_o = 32'd0; m_cso = 1'b0; m_irq = 1'b0;
  endtask

  // One bus cycle: drive, advance the model by the register-map rules, step the clock.
  task automatic cyc(input int cs, input int wr, input int a, input logic [31:0] d);
    logic [1:0]  al;
    logic [31:0] rv, n_ar, n_cntr;
    logic [2:0]  n_ctrl;
    logic        n_ov, at_end, is_wr;
    al    = a[1:0];
    is_wr = (cs != 0) && (wr != 0);
    CS = (cs != 0); WR = (wr != 0); I = d;
    A  = ($urandom() & 32'hffff_fffc) | {30'd0, al};
    case (al)
      2'd0:    rv = {29'd0, m_ctrl};
      2'd1:    rv = m_ar;
      2'd2:    rv = m_cntr;
      default: rv = {30'd0, m_ov, m_ctrl[0]};
    endcase
    at_end = m_ctrl[0] && (m_cntr >= m_ar);
    n_cntr = !m_ctrl[0] ? m_cntr : (at_end ? 32'd0 : m_cntr + 32'd1);
    n_ctrl = (at_end && !m_ctrl[1]) ? (m_ctrl & 3'b110) : m_ctrl;
    n_ar   = m_ar;
    n_ov   = m_ov;
    if (is_wr && al == 2'd0) n_ctrl = d[2:0];
    if (is_wr && al == 2'd1) n_ar = d;
    if (is_wr && al == 2'd2) n_cntr = d;
    if (is_wr && al == 2'd3 && d[1]) n_ov = 1'b0;
    if (at_end) n_ov = 1'b1;
    @(posedge CLK); #1;
    m_o    = ((cs != 0) && (wr == 0)) ? rv : 32'd0;
    m_cso  = (cs != 0);
    m_irq  = m_ov & m_ctrl[2];
    m_ctrl = n_ctrl; m_ar = n_ar; m_cntr = n_cntr; m_ov = n_ov;
  endtask

  task automatic test_reset();
    logic [31:0] exp_r [4];
    exp_r = '{32'd0, 32'd7, 32'd0, 32'd0};
    cyc(1, 1, 2, 0); cyc(1, 1, 3, 2); cyc(1, 1, 1, 1); cyc(1, 1, 0, 7);
    repeat (4) cyc(0, 0, 0, 0);
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %0b want 1", IRQ); end
    cyc(1, 0, 1, 0);
    checks++; if (O !== 32'd1) begin errors++; $display("FAIL pre_reset_o got %0h want 1", O); end
    CS = 1'b0; WR = 1'b0;
    #2 RESETN = 1'b0;
    #1;
    checks++; if (O !== 32'd0) begin errors++; $display("FAIL reset_o got %0h want 0", O); end
    checks++; if (CSO !== 1'b0) begin errors++; $display("FAIL reset_cso got %0b want 0", CSO); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b want 0", IRQ); end
    repeat (2) @(posedge CLK);
    @(negedge CLK); RESETN = 1'b1; model_reset();
    @(posedge CLK); #1;
    repeat (3) cyc(0, 0, 0, 0);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL post_reset_irq got %0b want 0", IRQ); end
    for (int r = 0; r < 4; r++) begin
      cyc(1, 0, r, 0);
      checks++;
      if (O !== exp_r[r]) begin errors++; $display("FAIL reset_reg%0d got %0h want %0h", r, O, exp_r[r]); end
    end
  endtask

  task automatic test_periodic();
    logic [31:0] seq [6];
    seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
    cyc(1, 1, 0, 0); cyc(1, 1, 2, 0); cyc(1, 1, 3, 2); cyc(1, 1, 1, 4);
    cyc(1, 1, 0, 3);
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, 2, 0);
      checks++;
      if (O !== seq[k] || O !== m_o) begin errors++; $display("FAIL periodic_cntr%0d got %0d want %0d", k, O, seq[k]); end
    end
    cyc(1, 0, 3, 0);
    checks++; if (O !== 32'd3) begin errors++; $display("FAIL periodic_ov got %0h want 3", O); end
    cyc(1, 1, 0, 0);
    cyc(1, 1, 3, 1);
    cyc(1, 0, 3, 0);
    checks++; if (O !== 32'd2) begin errors++; $display("FAIL stat_w1_noclear got %0h want 2", O); end
    cyc(1, 1, 3, 2);
    cyc(1, 0, 3, 0);
    checks++; if (O !== 32'd0) begin errors++; $display("FAIL stat_w2_clear got %0h want 0", O); end
  endtask

  task automatic test_read_latency();
    cyc(1, 1, 0, 0); cyc(1, 1, 2, 10); cyc(1, 1, 1, 1000); cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 2, 0);
    checks++; if (O !== 32'd11) begin errors++; $display("FAIL rd_latency_o got %0d want 11", O); end
    checks++; if (CSO !== 1'b1) begin errors++; $display("FAIL rd_latency_cso got %0b want 1", CSO); end
    cyc(0, 0, 0, 0);
    checks++; if (O !== 32'd0) begin errors++; $display("FAIL rd_idle_o got %0h want 0", O); end
    checks++; if (CSO !== 1'b0) begin errors++; $display("FAIL rd_idle_cso got %0b want 0", CSO); end
    cyc(1, 0, 2, 0);
    checks++; if (O !== 32'd13) begin errors++; $display("FAIL rd_after_idle got %0d want 13", O); end
  endtask

  task automatic test_oneshot();
    cyc(1, 1, 0, 0); cyc(1, 1, 2, 0); cyc(1, 1, 3, 2); cyc(1, 1, 1, 2);
    cyc(1, 1, 0, 1);
    repeat (5) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    checks++; if (O !== 32'd0) begin errors++; $display("FAIL oneshot_ctrl got %0h want 0", O); end
    cyc(1, 0, 3, 0);
    checks++; if (O !== 32'd2) begin errors++; $display("FAIL oneshot_stat got %0h want 2", O); end
    cyc(1, 0, 2, 0);
    checks++; if (O !== 32'd0) begin errors++; $display("FAIL oneshot_cntr got %0h want 0", O); end
  endtask

  task automatic test_collisions();
    // clear racing a wrap
    cyc(1, 1, 0, 0); cyc(1, 1, 2, 0); cyc(1, 1, 3, 2); cyc(1, 1, 1, 2);
    cyc(1, 1, 0, 3);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 1, 3, 2);
    cyc(1, 0, 3, 0);
    checks++; if (O !== 32'd3) begin errors++; $display("FAIL clear_vs_wrap got %0h want 3", O); end
    // count write above the limit
    cyc(1, 1, 0, 0); cyc(1, 1, 2, 0); cyc(1, 1, 3, 2); cyc(1, 1, 1, 5);
    cyc(1, 1, 0, 3);
    cyc(1, 1, 2, 100);
    cyc(1, 0, 3, 0);
    checks++; if (O !== 32'd1) begin errors++; $display("FAIL cntr_write_no_ov got %0h want 1", O); end
    cyc(1, 0, 2, 0);
    checks++; if (O !== 32'd0) begin errors++; $display("FAIL cntr_over_ar_wrap got %0d want 0", O); end
    cyc(1, 0, 3, 0);
    checks++; if (O !== 32'd3) begin errors++; $display("FAIL cntr_over_ar_ov got %0h want 3", O); end
    // zero limit
    cyc(1, 1, 0, 0); cyc(1, 1, 2, 0); cyc(1, 1, 1, 0); cyc(1, 1, 3, 2);
    cyc(1, 1, 0, 3);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 3, 2);
      cyc(1, 0, 3, 0);
      checks++; if (O !== 32'd3) begin errors++; $display("FAIL ar0_ov%0d got %0h want 3", k, O); end
      cyc(1, 0, 2, 0);
      checks++; if (O !== 32'd0) begin errors++; $display("FAIL ar0_cntr%0d got %0d want 0", k, O); end
    end
    // control write racing a one-shot end
    cyc(1, 1, 0, 0); cyc(1, 1, 2, 0); cyc(1, 1, 1, 1); cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 5);
    cyc(1, 0, 0, 0);
    checks++; if (O !== 32'd5) begin errors++; $display("FAIL ctrl_vs_oneshot got %0h want 5", O); end
  endtask

  task automatic test_irq();
    cyc(1, 1, 0, 0); cyc(1, 1, 2, 0); cyc(1, 1, 3, 2); cyc(1, 1, 1, 1);
    cyc(1, 1, 0, 7);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_lag got %0b want 0", IRQ); end
    cyc(1, 0, 3, 0);
    checks++; if (O !== 32'd3) begin errors++; $display("FAIL irq_ov_set got %0h want 3", O); end
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_rise got %0b want 1", IRQ); end
    cyc(1, 1, 0, 4);
    cyc(1, 1, 3, 2);
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_hold got %0b want 1", IRQ); end
    cyc(0, 0, 0, 0);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_drop got %0b want 0", IRQ); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    int cs, wr, a;
    for (int n = 0; n < 400; n++) begin
      cs = ($urandom_range(0, 3) != 0) ? 1 : 0;
      wr = $urandom_range(0, 1);
      a  = $urandom_range(0, 3);
      d  = ($urandom_range(0, 7) == 0) ? $urandom() : $urandom_range(0, 8);
      cyc(cs, wr, a, d);
      checks++; if (O !== m_o) begin errors++; $display("FAIL rand_o n=%0d got %0h want %0h", n, O, m_o); end
      checks++; if (CSO !== m_cso) begin errors++; $display("FAIL rand_cso n=%0d got %0b want %0b", n, CSO, m_cso); end
      checks++; if (IRQ !== m_irq) begin errors++; $display("FAIL rand_irq n=%0d got %0b want %0b", n, IRQ, m_irq); end
    end
  endtask

  initial begin
    RESETN = 1'b0; CS = 1'b0; WR = 1'b0; A = 32'd0; I = 32'd0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK); RESETN = 1'b1;
    @(posedge CLK); #1;
    test_reset();
    test_periodic();
    test_read_latency();
    test_oneshot();
    test_collisions();
    test_irq();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
